// File: rtl/dlfloat_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dlfloat_pkg
//  Description : Shared DLFloat16 constants, loader FSM encodings and the
//                operand sanitiser helper.
//  Revision    : 1.0  initial release
// ============================================================================
package dlfloat_pkg;

    localparam int DLF_W     = 16;
    localparam int DLF_EXP_W = 6;
    localparam int DLF_MAN_W = 9;

    localparam logic [DLF_W-1:0]     DLF_ZERO    = 16'h0000;
    localparam logic [DLF_W-1:0]     DLF_INF     = 16'hFFFF;
    localparam logic [DLF_EXP_W-1:0] DLF_EXP_MAX = 6'd63;

    typedef enum logic [1:0] {
        A_LO = 2'd0,
        A_HI = 2'd1,
        B_LO = 2'd2,
        B_HI = 2'd3
    } loader_state_t;

    // Subnormals flush to a signless zero; any non-canonical max-exponent
    // encoding collapses onto the single inf/NaN code.
    function automatic logic [DLF_W-1:0] dlf_sanitise(input logic [DLF_W-1:0] v);
        logic [DLF_EXP_W-1:0] e;
        logic [DLF_MAN_W-1:0] m;
        e = v[DLF_W-2 -: DLF_EXP_W];
        m = v[DLF_MAN_W-1:0];
        if (e == '0 && m != '0) begin
            return DLF_ZERO;
        end
        if (e == DLF_EXP_MAX && v != DLF_INF) begin
            return DLF_INF;
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dlfloat_op_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : dlfloat_op_fifo
//  Description : Synchronous FIFO with a registered head-entry output,
//                occupancy counter and full/empty flags.
//  Revision    : 1.0  initial release
// ============================================================================
module dlfloat_op_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 33,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_dout;

    logic             w_push;
    logic             w_pop;
    logic [PTR_W-1:0] w_wr_ptr_nxt;
    logic [PTR_W-1:0] w_rd_ptr_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic [WIDTH-1:0] w_head_nxt;

    assign full  = (r_count == CNT_W'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign dout  = r_dout;

    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    assign w_wr_ptr_nxt = w_push ? r_wr_ptr + PTR_W'(1) : r_wr_ptr;
    assign w_rd_ptr_nxt = w_pop  ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // The next head comes straight from din when it lands in the slot the
    // read pointer is about to point at; otherwise from storage.
    assign w_head_nxt = (w_push && (r_wr_ptr == w_rd_ptr_nxt)) ? din : r_mem[w_rd_ptr_nxt];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_dout   <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
            if (w_count_nxt != '0) begin
                r_dout <= w_head_nxt;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dlfloat_operand_loader.sv
`default_nettype none
// ============================================================================
//  Module      : dlfloat_operand_loader
//  Description : Assembles byte-serial DLFloat16 operand pairs and queues them
//                for the MAC. Define DLF_OPERAND_CHECK_EN to sanitise operands.
//  Revision    : 1.0  initial release
// ============================================================================
module dlfloat_operand_loader
    import dlfloat_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    input  logic             byte_last,
    output logic             byte_ready,
    input  logic             abort,
    output logic [15:0]      op_a,
    output logic [15:0]      op_b,
    output logic             op_last,
    output logic             op_valid,
    input  logic             op_ready,
    output logic [CNT_W-1:0] fifo_count,
    output logic             chk_flag
);

    localparam int ENTRY_W = 2 * DLF_W + 1;

    loader_state_t      r_state;
    loader_state_t      w_state_nxt;
    logic [DLF_W-1:0]   r_a;
    logic [7:0]         r_b_lo;

    logic               w_xfer;
    logic               w_push;
    logic               w_full;
    logic               w_empty;
    logic [DLF_W-1:0]   w_raw_b;
    logic [DLF_W-1:0]   w_op_a;
    logic [DLF_W-1:0]   w_op_b;
    logic [ENTRY_W-1:0] w_din;
    logic [ENTRY_W-1:0] w_dout;

    // Depends only on registered state so op_ready never reaches byte_ready.
    assign byte_ready = (r_state != B_HI) | ~w_full;

    assign w_xfer  = byte_valid & byte_ready & ~abort;
    assign w_push  = w_xfer & (r_state == B_HI);
    assign w_raw_b = {byte_in, r_b_lo};

    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = A_LO;
        end else if (w_xfer) begin
            case (r_state)
                A_LO:    w_state_nxt = A_HI;
                A_HI:    w_state_nxt = B_LO;
                B_LO:    w_state_nxt = B_HI;
                B_HI:    w_state_nxt = A_LO;
                default: w_state_nxt = A_LO;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= A_LO;
            r_a     <= '0;
            r_b_lo  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_xfer) begin
                case (r_state)
                    A_LO:    r_a[7:0]  <= byte_in;
                    A_HI:    r_a[15:8] <= byte_in;
                    B_LO:    r_b_lo    <= byte_in;
                    default: ;
                endcase
            end
        end
    end

`ifdef DLF_OPERAND_CHECK_EN
    logic r_chk_flag;

    assign w_op_a   = dlf_sanitise(r_a);
    assign w_op_b   = dlf_sanitise(w_raw_b);
    assign chk_flag = r_chk_flag;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_chk_flag <= 1'b0;
        end else if (w_push && ((w_op_a != r_a) || (w_op_b != w_raw_b))) begin
            r_chk_flag <= 1'b1;
        end
    end
`else
    assign w_op_a   = r_a;
    assign w_op_b   = w_raw_b;
    assign chk_flag = 1'b0;
`endif

    assign w_din = {w_op_a, w_op_b, byte_last};

    dlfloat_op_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .din   (w_din),
        .pop   (op_ready),
        .dout  (w_dout),
        .count (fifo_count),
        .full  (w_full),
        .empty (w_empty)
    );

    assign op_valid = ~w_empty;
    assign op_a     = w_dout[ENTRY_W-1 -: DLF_W];
    assign op_b     = w_dout[DLF_W:1];
    assign op_last  = w_dout[0];

endmodule
`default_nettype wire
